cmd_stream_fifo: RTL

Parametrised AXI-Stream command buffer between the PS command master and the command scheduler. It replaces the fixed 16x128 command FIFO with a configurable width and depth. It adds a release gate so the PS can pre-load a batch of commands and launch them together, plus occupancy, peak and stall telemetry packed into a 32-bit GPIO status word. It is single-clock, first-word-fall-through, with registered state only.

---
 rtl/cmd_stream_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/cmd_stream_fifo.sv
// First-word-fall-through AXI-Stream command buffer with a release gate,
// occupancy/peak/stall telemetry and a packed GPIO status word.
module cmd_stream_fifo #(
  parameter int          DATA_WIDTH  = 128,
  parameter int          DEPTH       = 16,
  parameter logic [15:0] STATUS_ID   = 16'd13,
  parameter int          COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   axi_aclk,
  input  logic                   axi_rst,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   gate_en,
  input  logic                   flush,
  input  logic                   peak_clr,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [COUNT_WIDTH-1:0] peak_count,
  output logic [15:0]            stall_count,
  output logic [31:0]            status_word
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic                   gate_q;
  logic                   push;
  logic                   pop;
  logic                   out_stall;
  logic [COUNT_WIDTH-1:0] count_next;

  // tready is derived from registered count only, so a same-cycle pop never raises it
  assign s_axis_tready = (count != FULL_COUNT) && !flush;
  assign m_axis_tvalid = gate_q && (count != '0);
  assign m_axis_tdata  = mem[rd_ptr];
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign out_stall     = m_axis_tvalid && !m_axis_tready;
  assign status_word   = {STATUS_ID, 16'(count)};

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count + COUNT_WIDTH'(1);
    else if (pop && !push)
      count_next = count - COUNT_WIDTH'(1);
  end

  always_ff @(posedge axi_aclk) begin
    if (push)
      mem[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      peak_count  <= '0;
      stall_count <= '0;
      gate_q      <= 1'b0;
    end else begin
      count <= count_next;
      // Holding the gate during an output stall keeps an asserted tvalid up until its handshake
      if (!out_stall)
        gate_q <= gate_en;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      if (peak_clr || (count_next > peak_count))
        peak_count <= count_next;
      if (s_axis_tvalid && !s_axis_tready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule
